mul_seq_param: RTL and testbench

- Parametrised successor to the 8-bit shift-add sequential multiplier.
- Computes a WIDTH x WIDTH product, unsigned or two's-complement signed (SIGNED parameter), over up to WIDTH cycles.
- Adds a done pulse and optional early termination.
- All additions go through the shared external combinational `sum` adder, sized 2*WIDTH, wired at the level above.

---
 rtl/mul_seq_param.sv | 106 ++++++++++
 tb/tb_mul_seq_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// Parametrised shift-add sequential multiplier (WIDTH x WIDTH, optional signed) using an external 2*WIDTH adder.
// Optional early termination when the remaining multiplier bits are zero: define MUL_SEQ_EARLY_TERM_EN.
module mul_seq_param #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   sum_in_a,
    output logic [2*WIDTH-1:0]   sum_in_b,
    input  logic [2*WIDTH-1:0]   sum_out
);

    localparam int PW        = 2 * WIDTH;
    localparam int CW        = $clog2(WIDTH);
    localparam bit IS_SIGNED = (SIGNED != 0);

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [PW-1:0]      r_result;
    logic               r_busy;
    logic               r_done;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic [PW-1:0]      w_final;

    // Signed mode works on magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign w_a_neg = IS_SIGNED && a_i[WIDTH-1];
    assign w_b_neg = IS_SIGNED && b_i[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~a_i + WIDTH'(1)) : a_i;
    assign w_b_mag = w_b_neg ? (~b_i + WIDTH'(1)) : b_i;

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(WIDTH - 1)) || ((r_mplier >> 1) == '0);
`else
    assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

    assign w_final  = (IS_SIGNED && r_neg) ? (~sum_out + PW'(1)) : sum_out;

    assign sum_in_a = (r_state == S_CALC) ? r_acc : '0;
    assign sum_in_b = ((r_state == S_CALC) && r_mplier[0]) ? r_mcand : '0;

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc    <= sum_out;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= w_final;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// Directed bench for mul_seq_param: unsigned 8-bit, signed 8-bit and unsigned 16-bit instances, each with its own adder.
// Expected busy lengths follow MUL_SEQ_EARLY_TERM_EN when the bench is built with it.
module tb_mul_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [7:0]  u8_a, u8_b;
    logic        u8_start, u8_busy, u8_done;
    logic [15:0] u8_res, u8_sa, u8_sb, u8_so;

    logic [7:0]  s8_a, s8_b;
    logic        s8_start, s8_busy, s8_done;
    logic [15:0] s8_res, s8_sa, s8_sb, s8_so;

    logic [15:0] u16_a, u16_b;
    logic        u16_start, u16_busy, u16_done;
    logic [31:0] u16_res, u16_sa, u16_sb, u16_so;

    assign u8_so  = u8_sa + u8_sb;
    assign s8_so  = s8_sa + s8_sb;
    assign u16_so = u16_sa + u16_sb;

    mul_seq_param #(.WIDTH(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .a_i(u8_a), .b_i(u8_b), .start(u8_start),
        .result(u8_res), .busy(u8_busy), .done(u8_done),
        .sum_in_a(u8_sa), .sum_in_b(u8_sb), .sum_out(u8_so)
    );

    mul_seq_param #(.WIDTH(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .a_i(s8_a), .b_i(s8_b), .start(s8_start),
        .result(s8_res), .busy(s8_busy), .done(s8_done),
        .sum_in_a(s8_sa), .sum_in_b(s8_sb), .sum_out(s8_so)
    );

    mul_seq_param #(.WIDTH(16), .SIGNED(0)) u_u16 (
        .clk(clk), .rst(rst), .a_i(u16_a), .b_i(u16_b), .start(u16_start),
        .result(u16_res), .busy(u16_busy), .done(u16_done),
        .sum_in_a(u16_sa), .sum_in_b(u16_sb), .sum_out(u16_so)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          sel;
    logic        obs_busy, obs_done;
    logic [31:0] obs_res;

    always_comb begin
        obs_busy = u8_busy;
        obs_done = u8_done;
        obs_res  = {16'h0, u8_res};
        case (sel)
            1: begin obs_busy = s8_busy;  obs_done = s8_done;  obs_res = {16'h0, s8_res}; end
            2: begin obs_busy = u16_busy; obs_done = u16_done; obs_res = u16_res;         end
            default: ;
        endcase
    end

    function automatic int exp_cyc(input int w, input logic [15:0] bmag);
        int c;
        c = 1;
        for (int i = 0; i < w; i++)
            if (bmag[i]) c = i + 1;
`ifdef MUL_SEQ_EARLY_TERM_EN
        return c;
`else
        return (c > w) ? c : w;
`endif
    endfunction

    task automatic drive(input int s, input logic [15:0] a, input logic [15:0] b, input logic st);
        case (s)
            0: begin u8_a = a[7:0];  u8_b = b[7:0];  u8_start = st;  end
            1: begin s8_a = a[7:0];  s8_b = b[7:0];  s8_start = st;  end
            default: begin u16_a = a; u16_b = b; u16_start = st; end
        endcase
    endtask

    // Returns at #1 after the accept edge with start released.
    task automatic launch(input int s, input string tag, input logic [15:0] a, input logic [15:0] b);
        sel = s;
        @(negedge clk);
        drive(s, a, b, 1'b1);
        @(posedge clk);
        #1;
        drive(s, a, b, 1'b0);
        check({tag, "_accept_busy"}, 64'(obs_busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int ecyc, input logic [31:0] eres);
        int  cyc = 0;
        int  dn  = 0;
        bit  fin = 1'b0;
        for (int k = 1; k <= 40 && !fin; k++) begin
            @(posedge clk);
            #1;
            cyc = k;
            if (obs_done) dn++;
            if (!obs_busy) fin = 1'b1;
        end
        check({tag, "_finished"}, 64'(fin), 64'd1);
        check({tag, "_cycles"}, 64'(cyc), 64'(ecyc));
        check({tag, "_done_pulses"}, 64'(dn), 64'd1);
        check({tag, "_result"}, 64'(obs_res), 64'(eres));
        @(posedge clk);
        #1;
        check({tag, "_done_low"}, 64'(obs_done), 64'd0);
    endtask

    task automatic run(input int s, input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] bmag, input logic [31:0] eres);
        launch(s, tag, a, b);
        wait_done(tag, exp_cyc((s == 2) ? 16 : 8, bmag), eres);
    endtask

    initial begin
        int dn;
        rst = 1'b1;
        sel = 0;
        drive(0, 16'h0, 16'h0, 1'b0);
        drive(1, 16'h0, 16'h0, 1'b0);
        drive(2, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_u8_busy", 64'(u8_busy), 64'd0);
        check("rst_u8_done", 64'(u8_done), 64'd0);
        check("rst_u8_result", 64'(u8_res), 64'd0);
        check("rst_s8_result", 64'(s8_res), 64'd0);
        check("rst_u16_result", 64'(u16_res), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_u16_sum_in_a", 64'(u16_sa), 64'd0);
        check("idle_u16_sum_in_b", 64'(u16_sb), 64'd0);

        run(0, "u8_3x2",     16'd3,   16'd2,   16'd2,   32'd6);
        run(0, "u8_5x5",     16'd5,   16'd5,   16'd5,   32'd25);
        run(0, "u8_4x3",     16'd4,   16'd3,   16'd3,   32'd12);
        run(0, "u8_255x255", 16'd255, 16'd255, 16'd255, 32'd65025);
        run(0, "u8_255x0",   16'd255, 16'd0,   16'd0,   32'd0);
        run(0, "u8_200x1",   16'd200, 16'd1,   16'd1,   32'd200);
        run(0, "u8_7x0",     16'd7,   16'd0,   16'd0,   32'd0);
        run(0, "u8_3x128",   16'd3,   16'h80,  16'h80,  32'd384);
        run(0, "u8_9x5",     16'd9,   16'd5,   16'd5,   32'd45);

        run(1, "s8_m3x5",     16'hFD, 16'h05, 16'd5,   32'hFFF1);
        run(1, "s8_m128xm128",16'h80, 16'h80, 16'd128, 32'h4000);
        run(1, "s8_127xm1",   16'h7F, 16'hFF, 16'd1,   32'hFF81);
        run(1, "s8_m1xm1",    16'hFF, 16'hFF, 16'd1,   32'h0001);

        run(2, "u16_max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        check("u16_idle_sum_in_a_after", 64'(u16_sa), 64'd0);
        check("u16_idle_sum_in_b_after", 64'(u16_sb), 64'd0);

        // Abort mid-operation: previous result (45) must be cleared and no done may follow.
        launch(0, "abort", 16'd255, 16'd255);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 64'(u8_busy), 64'd0);
        check("abort_result", 64'(u8_res), 64'd0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (u8_done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);

        // Start pulsed while busy is ignored.
        launch(0, "ignore", 16'd3, 16'd255);
        @(posedge clk);
        @(negedge clk);
        drive(0, 16'd7, 16'd7, 1'b1);
        @(negedge clk);
        drive(0, 16'd7, 16'd7, 1'b0);
        wait_done("ignore", exp_cyc(8, 16'd255) - 2, 32'd765);
        repeat (3) @(posedge clk);
        #1;
        check("ignore_stays_idle", 64'(u8_busy), 64'd0);
        check("ignore_result_held", 64'(u8_res), 64'd765);

        // Start held through completion relaunches on the first idle edge.
        sel = 0;
        @(negedge clk);
        drive(0, 16'd2, 16'd255, 1'b1);
        @(posedge clk);
        #1;
        check("held_accept_busy", 64'(u8_busy), 64'd1);
        dn = 0;
        for (int k = 0; k < 40 && u8_busy; k++) begin
            @(posedge clk);
            #1;
            if (u8_done) dn++;
        end
        check("held_first_done", 64'(dn), 64'd1);
        check("held_first_result", 64'(u8_res), 64'd510);
        drive(0, 16'd3, 16'd255, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 16'd3, 16'd255, 1'b0);
        check("held_relaunch_busy", 64'(u8_busy), 64'd1);
        check("held_relaunch_done_low", 64'(u8_done), 64'd0);
        wait_done("held_second", exp_cyc(8, 16'd255), 32'd765);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
